// File: rtl/kalman_gain_pkg.sv
// Shared types and helpers for the sequential Kalman gain MAC (K = P_pred * S_inv).
// Supports DWIDTH up to MAX_DW bits.
package kalman_gain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam int unsigned MAX_DW    = 64;
    localparam int unsigned MAX_ACC_W = 2 * MAX_DW + 17;

    function automatic int unsigned idx_w(input int unsigned x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned m);
        return 2 * dw + $clog2(m) + 1;
    endfunction

    // Result layout: bit MAX_DW is the saturation flag, low dwidth bits are the word.
    function automatic logic [MAX_DW:0] round_sat(input logic signed [MAX_ACC_W-1:0] acc,
                                                  input int unsigned dwidth,
                                                  input int unsigned frac);
        logic signed [MAX_ACC_W-1:0] one;
        logic signed [MAX_ACC_W-1:0] rounded;
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] lo;
        logic [MAX_DW:0]             res;
        one     = MAX_ACC_W'(1);
        rounded = (acc + (one <<< (frac - 1))) >>> frac;
        hi      = (one <<< (dwidth - 1)) - one;
        lo      = -(one <<< (dwidth - 1));
        res     = '0;
        if (rounded > hi) begin
            res[MAX_DW]     = 1'b1;
            res[MAX_DW-1:0] = hi[MAX_DW-1:0];
        end else if (rounded < lo) begin
            res[MAX_DW]     = 1'b1;
            res[MAX_DW-1:0] = lo[MAX_DW-1:0];
        end else begin
            res[MAX_DW-1:0] = rounded[MAX_DW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/kalman_gain_seq_mac_fx_mac.sv
// Signed multiply-accumulate: the full-width product is loaded or added into
// the accumulator register on each enabled cycle.
module fx_mac #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned ACC_W  = 2 * DWIDTH + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     load,
    input  logic signed [DWIDTH-1:0] a,
    input  logic signed [DWIDTH-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DWIDTH-1:0] prod;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    acc_q;

    always_comb begin
        prod  = (2 * DWIDTH)'(a) * (2 * DWIDTH)'(b);
        acc_d = acc_q;
        if (en) begin
            acc_d = load ? ACC_W'(prod) : acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/kalman_gain_seq_mac.sv
// Kalman gain K = P_pred * S_inv over the first M state columns, one element at a
// time on a single MAC; operands via 1-cycle read ports, results via ready/valid.
module kalman_gain_seq_mac
    import kalman_gain_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned FRAC   = 16,
    parameter int unsigned N      = 12,
    parameter int unsigned M      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic                  p_rd_en,
    output logic [idx_w(N)-1:0]   p_rd_row,
    output logic [idx_w(M)-1:0]   p_rd_col,
    input  logic [DWIDTH-1:0]     p_rd_data,
    output logic                  s_rd_en,
    output logic [idx_w(M)-1:0]   s_rd_row,
    output logic [idx_w(M)-1:0]   s_rd_col,
    input  logic [DWIDTH-1:0]     s_rd_data,
    output logic                  k_wr_valid,
    input  logic                  k_wr_ready,
    output logic [idx_w(N)-1:0]   k_wr_row,
    output logic [idx_w(M)-1:0]   k_wr_col,
    output logic [DWIDTH-1:0]     k_wr_data
);

    localparam int unsigned RW = idx_w(N);
    localparam int unsigned CW = idx_w(M);
    localparam int unsigned AW = acc_w(DWIDTH, M);

    state_e             state_q, state_d;
    logic [RW-1:0]      i_q, i_d;
    logic [CW-1:0]      j_q, j_d;
    logic [CW-1:0]      k_q, k_d;
    logic               ovf_q, ovf_d;
    logic               fetch_q, fetch_d;
    logic               first_q, first_d;
    logic signed [AW-1:0] acc;
    logic [MAX_DW:0]    rs;
    logic               unused_rs;
    logic [DWIDTH-1:0]  wr_data;
    logic               wr_sat;

    fx_mac #(
        .DWIDTH (DWIDTH),
        .ACC_W  (AW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fetch_q),
        .load  (first_q),
        .a     ($signed(p_rd_data)),
        .b     ($signed(s_rd_data)),
        .acc   (acc)
    );

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        ovf_d      = ovf_q;
        // Read data returns one cycle after the strobe, so MAC control lags by one.
        fetch_d    = (state_q == ST_FETCH);
        first_d    = (state_q == ST_FETCH) && (k_q == '0);
        rs         = round_sat(MAX_ACC_W'(acc), DWIDTH, FRAC);
        unused_rs  = ^rs;
        wr_data    = rs[DWIDTH-1:0];
        wr_sat     = rs[MAX_DW];
        p_rd_en    = 1'b0;
        s_rd_en    = 1'b0;
        p_rd_row   = '0;
        p_rd_col   = '0;
        s_rd_row   = '0;
        s_rd_col   = '0;
        k_wr_valid = 1'b0;
        k_wr_row   = '0;
        k_wr_col   = '0;
        k_wr_data  = '0;
        done       = 1'b0;
        busy       = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_FETCH;
                    ovf_d   = 1'b0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            ST_FETCH: begin
                p_rd_en  = 1'b1;
                s_rd_en  = 1'b1;
                p_rd_row = i_q;
                p_rd_col = k_q;
                s_rd_row = k_q;
                s_rd_col = j_q;
                if (k_q == CW'(M - 1)) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: begin
                k_wr_valid = 1'b1;
                k_wr_row   = i_q;
                k_wr_col   = j_q;
                k_wr_data  = wr_data;
                if (wr_sat) ovf_d = 1'b1;
                if (k_wr_ready) begin
                    state_d = ST_FETCH;
                    if (j_q == CW'(M - 1)) begin
                        j_d = '0;
                        if (i_q == RW'(N - 1)) begin
                            i_d     = '0;
                            state_d = ST_DONE;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including the write handshake; ovf is retained.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            ovf_d   = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            ovf_q   <= 1'b0;
            fetch_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
            fetch_q <= fetch_d;
            first_q <= first_d;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_kalman_gain_seq_mac.sv
// Bench for kalman_gain_seq_mac: matrix-product model with expected-write queue,
// checked every cycle a result is presented.
module tb_kalman_gain_seq_mac;

    localparam int unsigned DW  = 32;
    localparam int unsigned FR  = 16;
    localparam int unsigned NN  = 12;
    localparam int unsigned MM  = 6;
    localparam int unsigned LAT = NN * MM * (MM + 2) + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        k_wr_ready = 1'b1;
    logic        busy, done, ovf, p_rd_en, s_rd_en, k_wr_valid;
    logic [3:0]  p_rd_row, k_wr_row;
    logic [2:0]  p_rd_col, s_rd_row, s_rd_col, k_wr_col;
    logic [31:0] p_rd_data, s_rd_data, k_wr_data;

    logic signed [31:0] p_mem [NN][MM];
    logic signed [31:0] s_mem [MM][MM];

    typedef struct packed {
        logic [3:0]  row;
        logic [2:0]  col;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  stalls = 0;
    int  done_seen = 0;
    int  wr_count = 0;
    int  bp_mode = 0;
    bit  exp_ovf = 1'b0;
    bit  hold_prev = 1'b0;

    always #5 clk = ~clk;

    kalman_gain_seq_mac #(
        .DWIDTH (DW),
        .FRAC   (FR),
        .N      (NN),
        .M      (MM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .p_rd_en    (p_rd_en),
        .p_rd_row   (p_rd_row),
        .p_rd_col   (p_rd_col),
        .p_rd_data  (p_rd_data),
        .s_rd_en    (s_rd_en),
        .s_rd_row   (s_rd_row),
        .s_rd_col   (s_rd_col),
        .s_rd_data  (s_rd_data),
        .k_wr_valid (k_wr_valid),
        .k_wr_ready (k_wr_ready),
        .k_wr_row   (k_wr_row),
        .k_wr_col   (k_wr_col),
        .k_wr_data  (k_wr_data)
    );

    // Memories with 1-cycle read latency; garbage returned when not strobed.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        p_rd_data <= p_rd_en ? p_mem[p_rd_row][p_rd_col] : $urandom;
        s_rd_data <= s_rd_en ? s_mem[s_rd_row][s_rd_col] : $urandom;
    end

    always @(posedge clk) begin
        #1;
        k_wr_ready = (bp_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [32:0] model_k(input int i, input int j);
        logic signed [71:0] sum;
        logic signed [71:0] r;
        sum = '0;
        for (int k = 0; k < MM; k++) sum += 72'(p_mem[i][k]) * 72'(s_mem[k][j]);
        r = (sum + 72'sd32768) >>> FR;
        if (r > 72'sd2147483647) return {1'b1, 32'h7FFFFFFF};
        if (r < -72'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, r[31:0]};
    endfunction

    task automatic load_expected();
        logic [32:0] m;
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < NN; i++) begin
            for (int j = 0; j < MM; j++) begin
                m = model_k(i, j);
                exp_q.push_back({4'(i), 3'(j), m[31:0]});
                exp_ovf |= m[32];
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (k_wr_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=row%0d col%0d %h required=none",
                             k_wr_row, k_wr_col, k_wr_data);
                end else begin
                    chk("k_write", {25'd0, k_wr_row, k_wr_col, k_wr_data}, {25'd0, exp_q[0]});
                    if (k_wr_ready) begin
                        void'(exp_q.pop_front());
                        wr_count++;
                    end else begin
                        stalls++;
                    end
                end
            end else if (hold_prev && exp_q.size() != 0) begin
                chk("valid_held_in_stall", 64'(k_wr_valid), 64'd1);
            end
            if (done) begin
                done_seen++;
                chk("done_latency", 64'(cyc - start_cyc), 64'(LAT + stalls));
                chk("writes_left_at_done", 64'(exp_q.size()), 64'd0);
            end
            hold_prev = k_wr_valid && !k_wr_ready;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic set_identity();
        for (int i = 0; i < NN; i++)
            for (int k = 0; k < MM; k++) p_mem[i][k] = 32'((i * 6 + k) << 16);
        for (int k = 0; k < MM; k++)
            for (int j = 0; j < MM; j++) s_mem[k][j] = (k == j) ? 32'h00010000 : 32'h0;
    endtask

    task automatic set_fill(input logic [31:0] p00, input logic [31:0] pv,
                            input logic [31:0] s00, input logic [31:0] sv);
        for (int i = 0; i < NN; i++)
            for (int k = 0; k < MM; k++) p_mem[i][k] = (i == 0 && k == 0) ? p00 : pv;
        for (int k = 0; k < MM; k++)
            for (int j = 0; j < MM; j++) s_mem[k][j] = (k == 0 && j == 0) ? s00 : sv;
    endtask

    task automatic set_random();
        for (int i = 0; i < NN; i++)
            for (int k = 0; k < MM; k++) p_mem[i][k] = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        for (int k = 0; k < MM; k++)
            for (int j = 0; j < MM; j++) s_mem[k][j] = 32'($urandom_range(0, 262143)) - 32'd131072;
    endtask

    task automatic start_job(input int bp);
        load_expected();
        stalls    = 0;
        done_seen = 0;
        wr_count  = 0;
        bp_mode   = bp;
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic finish_job();
        int t;
        t = 0;
        while (done_seen == 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        if (done_seen == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done");
        end
        repeat (4) @(posedge clk);
        #1;
        bp_mode = 0;
        chk("single_done", 64'(done_seen), 64'd1);
        chk("ovf_after_job", 64'(ovf), 64'(exp_ovf));
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("reset_outputs", {26'd0, busy, done, ovf, p_rd_en, s_rd_en, k_wr_valid, p_rd_row,
                              p_rd_col, s_rd_row, s_rd_col, k_wr_row, k_wr_col, k_wr_data}, 64'd0);
        #14 rst_n = 1'b1;

        set_identity();
        chk("model_pin_identity", 64'(model_k(11, 5)), {31'd0, 1'b0, 32'h00470000});
        start_job(0);
        finish_job();

        set_fill(32'h00000003, 32'h0, 32'h00008000, 32'h0);
        chk("model_pin_round_pos", 64'(model_k(0, 0)), {31'd0, 1'b0, 32'h00000002});
        start_job(0);
        finish_job();

        set_fill(32'hFFFFFFFD, 32'h0, 32'h00008000, 32'h0);
        chk("model_pin_round_neg", 64'(model_k(0, 0)), {31'd0, 1'b0, 32'hFFFFFFFF});
        start_job(0);
        finish_job();

        set_fill(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
        chk("model_pin_sat_pos", 64'(model_k(3, 4)), {31'd0, 1'b1, 32'h7FFFFFFF});
        start_job(0);
        finish_job();

        set_fill(32'h80000000, 32'h80000000, 32'h7FFF0000, 32'h7FFF0000);
        chk("model_pin_sat_neg", 64'(model_k(0, 0)), {31'd0, 1'b1, 32'h80000000});
        start_job(0);
        finish_job();

        set_identity();
        start_job(0);
        finish_job();

        start_job(1);
        finish_job();

        // Second start a few cycles into FETCH must be ignored.
        start_job(0);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_job();

        start_job(0);
        for (int t = 0; t < 2000 && wr_count < 9; t++) @(posedge clk);
        chk("abort_reached_element10", 64'(wr_count), 64'd9);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_idle_next", {61'd0, busy, k_wr_valid, done}, 64'd0);
        repeat (700) @(posedge clk);
        chk("abort_no_done", 64'(done_seen), 64'd0);

        set_random();
        start_job(0);
        finish_job();

        set_identity();
        start_job(0);
        for (int t = 0; t < 100 && !k_wr_valid; t++) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset_outputs", {26'd0, busy, done, ovf, p_rd_en, s_rd_en, k_wr_valid,
                                    p_rd_row, p_rd_col, s_rd_row, s_rd_col, k_wr_row, k_wr_col,
                                    k_wr_data}, 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        start_job(0);
        finish_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kalman_gain_seq_mac.md
Name: kalman_gain_seq_mac

Overview:
Parametrised successor to the fixed 12x6 Kalman gain stage. It computes K = P_pred·Hᵀ·S⁻¹, with H selecting the first M state columns, for any N×M problem: K[i][j] = Σ_{k<M} P_pred[i][k]·S_inv[k][j]. It works in signed fixed point on a single time-multiplexed MAC. Operands come through 1-cycle-latency read ports and results leave through a ready/valid write port. It sits between the covariance-prediction/inverse stage and the state-update stage.

Parameters:
DWIDTH, 32, signed fixed-point word width of operands and results
FRAC, 16, fractional bits (Q(DWIDTH-FRAC).FRAC); 1 ≤ FRAC < DWIDTH
N, 12, state dimension (rows of K), ≥ 1
M, 6, measurement dimension (cols of K, inner length), ≥ 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request; accepted only in IDLE
abort  in  1  synchronous cancel; returns to IDLE, no done
busy  out  1  high from cycle after accepted start until DONE cycle inclusive
done  out  1  1-cycle pulse after last K element written
ovf  out  1  sticky: any result saturated; cleared on accepted start
p_rd_en  out  1  read strobe, P_pred port
p_rd_row  out  clog2(N)  row index i
p_rd_col  out  clog2(M)  column index k
p_rd_data  in  DWIDTH  P_pred[i][k], valid exactly 1 cycle after p_rd_en
s_rd_en  out  1  read strobe, S_inv port
s_rd_row  out  clog2(M)  row index k
s_rd_col  out  clog2(M)  column index j
s_rd_data  in  DWIDTH  S_inv[k][j], valid exactly 1 cycle after s_rd_en
k_wr_valid  out  1  result valid
k_wr_ready  in  1  sink accepts when valid&ready
k_wr_row  out  clog2(N)  i
k_wr_col  out  clog2(M)  j
k_wr_data  out  DWIDTH  K[i][j]
(index widths use max(1, clog2(x)).)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset all outputs are 0, state is IDLE, counters i/j/k are 0, the accumulator is 0 and ovf is 0. Reset mid-operation drops all progress silently.
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: when start=1 (and abort=0), clear ovf, set i=j=k=0 and go to FETCH. Otherwise stay.
- FETCH: assert p_rd_en and s_rd_en together, with p=(i,k) and s=(k,j). Do this for M consecutive cycles, k=0..M-1, then go to DRAIN. Read strobes are low in every other state.
- MAC: on the cycle after each fetch, the product P·S (2·DWIDTH signed) is loaded into the accumulator if it is the k=0 product, and added otherwise. Accumulator width is 2·DWIDTH+clog2(M)+1, so it never wraps.
- DRAIN: one cycle to absorb the final product, then go to WRITE.
- WRITE: k_wr_valid=1, with row/col/data held stable until k_wr_ready=1.
  - The data value is: add 2^(FRAC-1) to the accumulator, arithmetic-shift right by FRAC, then saturate to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1]. Any saturation sets ovf.
  - On the handshake, j++. On j wrap (j=M-1), j=0 and i++.
  - If (i,j) was (N-1,M-1), go to DONE. Otherwise go to FETCH.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE.
- Latency with k_wr_ready tied high: M+2 cycles per element. done is asserted exactly N·M·(M+2)+1 cycles after the cycle in which start was sampled. Each ready-low cycle adds one.
- start while not IDLE is ignored, including in the DONE cycle.
- abort (any non-IDLE state): next cycle the block is in IDLE with busy=0, k_wr_valid=0 and no done. ovf keeps its value. abort takes priority over start and over the WRITE handshake in the same cycle.
- Read-data values on cycles not following a strobe are don't-care and must not affect results.

Decomposition:
- Package kalman_gain_pkg holds:
  - the state enum type;
  - ACC_W and index-width localparam functions;
  - the pure function round_sat(acc) returning {sat_flag, DWIDTH result}.
- Sub-module fx_mac: registered multiply, with load/accumulate control and an accumulator output. The FSM, counters and port logic stay in the top.

Test Plan:
- Identity: N=12, M=6, FRAC=16, S_inv=I (0x00010000 on diagonal), P[i][k]=(i·6+k)<<16, ready=1. Required: K[i][j]=P[i][j]; 72 writes in row-major order; done exactly 577 cycles after start; ovf=0.
- Rounding: N=M=1, P=0x00000003, S=0x00008000 (0.5). Raw product 0x18000 >> 16 with round gives K=0x00000002. P=0xFFFFFFFD gives K=0xFFFFFFFF.
- Saturation: N=M=2, all P=S=0x7FFF0000. Required: every K=0x7FFFFFFF, ovf=1. A following start with small values clears ovf to 0.
- Backpressure: identity case with k_wr_ready random at 50%. Required: data/row/col stable while valid&!ready, no lost or duplicated writes, done delayed by exactly the count of stalled cycles.
- Control: start during FETCH is ignored, giving a single done. abort during the 10th element gives idle next cycle and no done. A fresh start then completes correctly.
- Reset: deassert rst_n mid-WRITE. Required: all outputs 0 immediately (asynchronous). After release, a start produces full correct results.
